lcd_cmd_seq: RTL and testbench
==============================

LCD_CMD_SEQ -- requirements
Module: lcd_cmd_seq

Interface
REQ-001 Parameter SCRIPT_LEN, default 32: number of command-ROM words in one script, range 2..32.
REQ-002 Parameter DONE_TIMEOUT, default 255: maximum cycles allowed from issuing cmd 0 to LCD done, range 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a script; honoured only in IDLE.
REQ-006 CROM_rd  output  1  command-ROM read enable.
REQ-007 CROM_A  output  5  command-ROM address.
REQ-008 CROM_Q  input  4  command-ROM data; valid on the cycle after CROM_rd is asserted.
REQ-009 cmd  output  4  command to the LCD controller.
REQ-010 cmd_valid  output  1  command strobe to the LCD controller.
REQ-011 busy  input  1  LCD controller busy; a command is accepted only on a cycle with busy=0.
REQ-012 done  input  1  LCD controller image-write complete.
REQ-013 seq_busy  output  1  sequencer active, high in every state except IDLE.
REQ-014 seq_done  output  1  script finished normally; level output, held until the next start.
REQ-015 seq_err  output  1  timeout occurred; level output, held until the next start.
REQ-016 cmd_cnt  output  6  number of commands issued in the current script, including the final 0.

Function
REQ-017 FSM states are IDLE, FETCH, WAIT_Q, ISSUE, WAIT_DONE, FIN and ERR.
REQ-018 IDLE -> FETCH on start; FIN and ERR also -> FETCH on start, and clear seq_done, seq_err, cmd_cnt and addr.
REQ-019 FETCH: CROM_rd=1 and CROM_A=addr for exactly one cycle; then -> WAIT_Q.
REQ-020 WAIT_Q: capture CROM_Q into cmd_reg.
  - If cmd_reg is 12..15 (illegal), it is not issued: increment addr and -> FETCH.
  - Otherwise -> ISSUE.
REQ-021 ISSUE, busy=1: stall with cmd_valid=0; stalling has no limit.
REQ-022 ISSUE, busy=0: assert cmd_valid=1 and cmd=cmd_reg for exactly one cycle, and increment cmd_cnt (saturating at 63).
  - If cmd_reg=0 -> WAIT_DONE.
  - Otherwise increment addr and -> FETCH.
REQ-023 End of script without a 0: if addr reaches SCRIPT_LEN-1 and that word is not 0, the next issue substitutes cmd 0.
  - If the last word is illegal, the sequencer issues 0 instead of skipping it.
REQ-024 Whenever cmd_valid=0, cmd SHALL be 4'hF (NOP); the LCD controller samples cmd on every non-busy cycle.
REQ-025 WAIT_DONE: a timer counts from 0 each cycle.
  - done=1 -> FIN.
  - Timer reaching DONE_TIMEOUT with done still 0 -> ERR.
  - done wins if both occur in the same cycle.
REQ-026 FIN: seq_done=1. ERR: seq_err=1. seq_busy=0 in both FIN and ERR.
REQ-027 A start pulse in any state other than IDLE, FIN or ERR is ignored.
REQ-028 addr is 5 bits and never wraps; FETCH never drives CROM_A above SCRIPT_LEN-1.
REQ-029 cmd_valid never asserts on two consecutive cycles.
REQ-030 cmd_valid never asserts while busy=1.

Reset
REQ-031 On reset=1 at a clock edge, in any state including mid-script, the block SHALL return to IDLE.
REQ-032 Outputs after reset: CROM_rd=0, CROM_A=0, cmd=4'hF, cmd_valid=0, seq_busy=0, seq_done=0, seq_err=0, cmd_cnt=0.
REQ-033 Internal state after reset: addr and timer cleared.
REQ-034 reset takes priority over start in the same cycle.

Verification
REQ-035 Script {1,5,9,0}, busy=0 throughout, done two cycles after the 0 -> cmd_valid pulses carry 1, 5, 9, 0 in order, 3 cycles apart; cmd_cnt=4; seq_done=1.
REQ-036 Script {4,0}, busy held 1 for 10 cycles before the first issue -> no cmd_valid during the stall; cmd 4 issues on the first busy=0 cycle.
REQ-037 Script {13,2,15,0} -> only 2 and 0 are issued; cmd_cnt=2; cmd=4'hF on every non-valid cycle.
REQ-038 SCRIPT_LEN=4, script {3,3,3,7} -> issues 3, 3, 3, 0; cmd 7 is never issued; seq_done=1 after done.
REQ-039 Script {0}, done never asserted, DONE_TIMEOUT=5 -> seq_err=1 six cycles after the issue; seq_done stays 0; a new start clears seq_err.
REQ-040 reset asserted in ISSUE during a busy stall -> next cycle state is IDLE with all outputs at their reset values; a start afterwards refetches from address 0.

Source files
------------

// File: rtl/lcd_cmd_seq.sv
// Command sequencer: walks a command ROM, issues each legal command to the LCD
// controller, then waits for the controller's done with a bounded timeout.
module lcd_cmd_seq #(
  parameter int SCRIPT_LEN   = 32,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       CROM_rd,
  output logic [4:0] CROM_A,
  input  logic [3:0] CROM_Q,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  input  logic       busy,
  input  logic       done,
  output logic       seq_busy,
  output logic       seq_done,
  output logic       seq_err,
  output logic [5:0] cmd_cnt,
  output logic [2:0] state_dbg
);

  // Handshake: the LCD controller takes cmd on a cycle where cmd_valid=1 and
  // busy=0; cmd_valid is only ever raised with busy=0, so every strobe is a transfer.

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    WAIT_Q    = 3'd2,
    ISSUE     = 3'd3,
    WAIT_DONE = 3'd4,
    FIN       = 3'd5,
    ERR       = 3'd6
  } state_t;

  localparam logic [4:0] LAST_ADDR = 5'(SCRIPT_LEN - 1);
  localparam logic [7:0] TMO_LAST  = 8'(DONE_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [4:0] addr_q, addr_d;
  logic [3:0] cmd_q, cmd_d;
  logic [5:0] cnt_q, cnt_d;
  logic [7:0] timer_q, timer_d;
  logic       at_last;
  logic       illegal;

  assign at_last = (addr_q == LAST_ADDR);
  assign illegal = &CROM_Q[3:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= 5'd0;
      cmd_q   <= 4'd0;
      cnt_q   <= 6'd0;
      timer_q <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    CROM_rd   = 1'b0;
    CROM_A    = 5'd0;
    cmd       = 4'hF;
    cmd_valid = 1'b0;
    case (state_q)
      IDLE, FIN, ERR: begin
        if (start) begin
          state_d = FETCH;
          addr_d  = 5'd0;
          cnt_d   = 6'd0;
          timer_d = 8'd0;
        end
      end
      FETCH: begin
        CROM_rd = 1'b1;
        CROM_A  = addr_q;
        state_d = WAIT_Q;
      end
      WAIT_Q: begin
        // The final word always becomes the terminating 0, legal or not.
        if (at_last) begin
          cmd_d   = 4'd0;
          state_d = ISSUE;
        end else if (illegal) begin
          cmd_d   = CROM_Q;
          addr_d  = addr_q + 5'd1;
          state_d = FETCH;
        end else begin
          cmd_d   = CROM_Q;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!busy) begin
          cmd_valid = 1'b1;
          cmd       = cmd_q;
          if (cnt_q != 6'd63) cnt_d = cnt_q + 6'd1;
          if (cmd_q == 4'd0) begin
            timer_d = 8'd0;
            state_d = WAIT_DONE;
          end else begin
            addr_d  = addr_q + 5'd1;
            state_d = FETCH;
          end
        end
      end
      WAIT_DONE: begin
        if (done) begin
          state_d = FIN;
        end else if (timer_q == TMO_LAST) begin
          state_d = ERR;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign seq_busy  = (state_q != IDLE) && (state_q != FIN) && (state_q != ERR);
  assign seq_done  = (state_q == FIN);
  assign seq_err   = (state_q == ERR);
  assign cmd_cnt   = cnt_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Directed bench for lcd_cmd_seq (SCRIPT_LEN=4, DONE_TIMEOUT=5) with a ROM model
// and a scoreboard of expected issued commands.
module tb_lcd_cmd_seq;

  localparam int S_IDLE = 0, S_FETCH = 1, S_ISSUE = 3, S_WAIT_DONE = 4, S_FIN = 5, S_ERR = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy = 1'b0;
  logic       done = 1'b0;
  logic       CROM_rd;
  logic [4:0] CROM_A;
  logic [3:0] CROM_Q = 4'd0;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       seq_busy, seq_done, seq_err;
  logic [5:0] cmd_cnt;
  logic [2:0] state_dbg;

  logic [3:0] rom [0:3];
  logic [3:0] exp_q [$];
  int         valid_t [$];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic       prev_valid = 1'b0;

  lcd_cmd_seq #(.SCRIPT_LEN(4), .DONE_TIMEOUT(5)) dut (
    .clk(clk), .reset(reset), .start(start),
    .CROM_rd(CROM_rd), .CROM_A(CROM_A), .CROM_Q(CROM_Q),
    .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .done(done),
    .seq_busy(seq_busy), .seq_done(seq_done), .seq_err(seq_err),
    .cmd_cnt(cmd_cnt), .state_dbg(state_dbg)
  );

  // clock / ROM model
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (CROM_rd) CROM_Q <= rom[CROM_A[1:0]];

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard and per-cycle invariants
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (cmd_valid) begin
        check("valid_while_busy", 32'(busy), 32'd0);
        check("valid_back_to_back", 32'(prev_valid), 32'd0);
        if (exp_q.size() == 0) check("unexpected_cmd", 32'(cmd), 32'hEE);
        else check("cmd_value", 32'(cmd), 32'(exp_q.pop_front()));
        valid_t.push_back(cyc);
      end else begin
        check("cmd_nop", 32'(cmd), 32'hF);
      end
      if (CROM_rd) check("crom_a_range", 32'(CROM_A <= 5'd3), 32'd1);
      prev_valid = cmd_valid;
    end
  end

  // driver tasks
  task automatic load(input logic [3:0] w0, input logic [3:0] w1, input logic [3:0] w2,
                      input logic [3:0] w3);
    rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
    valid_t.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(state_dbg), S_IDLE);
    check({tag, "_crom_rd"}, 32'(CROM_rd), 32'd0);
    check({tag, "_crom_a"}, 32'(CROM_A), 32'd0);
    check({tag, "_cmd"}, 32'(cmd), 32'hF);
    check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_seq_busy"}, 32'(seq_busy), 32'd0);
    check({tag, "_seq_done"}, 32'(seq_done), 32'd0);
    check({tag, "_seq_err"}, 32'(seq_err), 32'd0);
    check({tag, "_cmd_cnt"}, 32'(cmd_cnt), 32'd0);
  endtask

  task automatic start_script(input string tag);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check({tag, "_fetch_state"}, 32'(state_dbg), S_FETCH);
    check({tag, "_fetch_rd"}, 32'(CROM_rd), 32'd1);
    check({tag, "_fetch_addr"}, 32'(CROM_A), 32'd0);
    check({tag, "_cnt_cleared"}, 32'(cmd_cnt), 32'd0);
    check({tag, "_flags_cleared"}, 32'({seq_busy, seq_done, seq_err}), 32'b100);
  endtask

  // leaves the caller at the negedge of the cycle that issued cmd 0
  task automatic wait_zero_issue(input string tag);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_valid && cmd == 4'd0) break;
    end
    if (k == 200) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s_issue0_timeout: observed no cmd 0, expected cmd 0 within 200 cycles", tag);
    end
  endtask

  task automatic give_done(input int delay);
    repeat (delay) @(posedge clk);
    #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
  endtask

  task automatic check_fin(input string tag, input int cnt);
    @(negedge clk);
    check({tag, "_fin_state"}, 32'(state_dbg), S_FIN);
    check({tag, "_seq_done"}, 32'(seq_done), 32'd1);
    check({tag, "_seq_busy"}, 32'(seq_busy), 32'd0);
    check({tag, "_seq_err"}, 32'(seq_err), 32'd0);
    check({tag, "_cmd_cnt"}, 32'(cmd_cnt), 32'(cnt));
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int k;
    load(4'd0, 4'd0, 4'd0, 4'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");

    // {1,5,9,0}: commands 3 cycles apart; a start during WAIT_DONE is ignored
    load(4'd1, 4'd5, 4'd9, 4'd0);
    exp_q = '{4'd1, 4'd5, 4'd9, 4'd0};
    start_script("s1");
    wait_zero_issue("s1");
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
    check_fin("s1", 4);
    check("s1_valid_count", 32'(valid_t.size()), 32'd4);
    if (valid_t.size() == 4)
      for (int i = 1; i < 4; i++) check("s1_spacing", 32'(valid_t[i] - valid_t[i-1]), 32'd3);

    // {4,0}: busy stall of 10 cycles before the first issue
    load(4'd4, 4'd0, 4'd0, 4'd0);
    exp_q = '{4'd4, 4'd0};
    busy = 1'b1;
    start_script("s2");
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("s2_stall_state", 32'(state_dbg), S_ISSUE);
    check("s2_stall_valid", 32'(cmd_valid), 32'd0);
    @(posedge clk); #1 busy = 1'b0;
    @(negedge clk);
    check("s2_first_free_valid", 32'(cmd_valid), 32'd1);
    check("s2_first_free_cmd", 32'(cmd), 32'd4);
    wait_zero_issue("s2");
    give_done(2);
    check_fin("s2", 2);

    // {13,2,15,0}: illegal words skipped
    load(4'd13, 4'd2, 4'd15, 4'd0);
    exp_q = '{4'd2, 4'd0};
    start_script("s3");
    wait_zero_issue("s3");
    give_done(1);
    check_fin("s3", 2);

    // {3,3,3,7}: last word replaced by 0
    load(4'd3, 4'd3, 4'd3, 4'd7);
    exp_q = '{4'd3, 4'd3, 4'd3, 4'd0};
    start_script("s4");
    wait_zero_issue("s4");
    give_done(2);
    check_fin("s4", 4);

    // {12,13,14,15}: illegal final word still issues 0
    load(4'd12, 4'd13, 4'd14, 4'd15);
    exp_q = '{4'd0};
    start_script("s5");
    wait_zero_issue("s5");
    give_done(2);
    check_fin("s5", 1);

    // {0}, no done: error six cycles after the issue
    load(4'd0, 4'd0, 4'd0, 4'd0);
    exp_q = '{4'd0};
    start_script("s6");
    wait_zero_issue("s6");
    repeat (5) @(negedge clk);
    check("s6_pre_err_state", 32'(state_dbg), S_WAIT_DONE);
    check("s6_pre_err_flag", 32'(seq_err), 32'd0);
    @(negedge clk);
    check("s6_err_state", 32'(state_dbg), S_ERR);
    check("s6_err_flag", 32'(seq_err), 32'd1);
    check("s6_err_done", 32'(seq_done), 32'd0);
    check("s6_err_busy", 32'(seq_busy), 32'd0);
    @(negedge clk);
    check("s6_err_held", 32'(seq_err), 32'd1);

    // restart from ERR clears seq_err; done on the last timer cycle wins
    exp_q = '{4'd0};
    start_script("s7");
    wait_zero_issue("s7");
    give_done(5);
    check_fin("s7", 1);

    // reset during a busy stall in ISSUE, then a clean rerun from address 0
    load(4'd6, 4'd0, 4'd0, 4'd0);
    busy = 1'b1;
    start_script("s8");
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (state_dbg == 3'(S_ISSUE)) break;
    end
    check("s8_reached_issue", 32'(state_dbg), S_ISSUE);
    @(posedge clk); #1 reset = 1'b1; start = 1'b1;
    @(posedge clk); #1 reset = 1'b0; start = 1'b0; busy = 1'b0;
    @(negedge clk);
    check_reset_outputs("s8_rst");
    exp_q = '{4'd6, 4'd0};
    start_script("s8b");
    wait_zero_issue("s8b");
    give_done(2);
    check_fin("s8b", 2);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
